heart_break_animator: RTL and testbench
=======================================

# heart_break_animator

Frame-rate animation controller that drives the position and mirror inputs of the two half-heart sprite renderers when a heart breaks. On a trigger it captures the heart's on-screen origin, holds the cracked halves still for a fixed number of frames, then lets the halves fall under constant gravity while drifting apart. It stops when both reach the floor line. It sits between game logic and the pixel pipeline; its outputs feed the left-half and right-half sprite instances directly.

## Interface
- HOLD_FRAMES, 8: frames the halves stay at the origin before falling
- GRAVITY, 1: per-frame velocity increment (px/frame²)
- VMAX, 12: terminal vertical velocity (px/frame), ≤ 15
- DRIFT, 1: per-frame horizontal separation step per half (px)
- FLOOR_Y, 720: floor line; a half lands when its bottom edge reaches it
- SCREEN_W, 1280; SPRITE_W, 8; SPRITE_H, 12: geometry
- TUMBLE_FRAMES, 4: mirror toggle period (only with HEART_TUMBLE_EN)
- clk_in  input  1  system/pixel clock
- rst_n_in  input  1  asynchronous, active-low reset
- trigger_in  input  1  single-cycle start request
- new_frame_in  input  1  single-cycle pulse, once per video frame
- origin_x_in  input  11  heart left edge at trigger
- origin_y_in  input  10  heart top edge at trigger
- left_x_out, right_x_out  output  11  half positions (to sprite x_in)
- left_y_out, right_y_out  output  10  half positions (to sprite y_in)
- left_mirror_out, right_mirror_out  output  1  to sprite mirror_in
- active_out  output  1  halves should be drawn
- done_out  output  1  one-cycle pulse on landing

## Operation
- States: IDLE, HOLD, FALL, DONE.
- IDLE: trigger_in=1 → left_x=origin_x, right_x=origin_x+SPRITE_W, both y=origin_y, vy=0, frame counter=0, go HOLD. new_frame_in ignored. trigger_in in the same cycle as new_frame_in: trigger taken, that frame not counted.
- HOLD: each new_frame_in increments the counter; on the HOLD_FRAMES-th pulse go FALL (no motion that frame).
- FALL, per new_frame_in:
  - vy_next = min(vy+GRAVITY, VMAX)
  - y_next = y + vy_next, computed 11 bits wide
  - left_x -= DRIFT, saturating at 0
  - right_x += DRIFT, saturating at SCREEN_W−SPRITE_W
- Landing: if y_next ≥ FLOOR_Y−SPRITE_H, y = FLOOR_Y−SPRITE_H and go DONE.
- DONE: lasts one cycle with done_out=1, then IDLE.
- Both halves always share y and vy.
- trigger_in outside IDLE is ignored.
- Positions hold their last values in IDLE.
- Origin with origin_y ≥ FLOOR_Y−SPRITE_H: lands on the first FALL frame.

## Timing
- All outputs registered.
- Reset values: positions 0, left_mirror_out=0, right_mirror_out=1, active_out=0, done_out=0, state IDLE, vy=0.
- Reset asserted mid-animation returns to these values immediately. No done_out is produced.
- trigger_in at cycle t: active_out=1 and positions valid at t+1.
- Motion: a new_frame_in at cycle t updates positions, visible at t+1.
- done_out is high at cycle t+1 after the landing frame pulse. active_out stays 1 through DONE and is 0 from t+2.
- new_frame_in while in DONE is ignored.

## Configuration
- HEART_TUMBLE_EN defined: during FALL, both mirror outputs toggle on every TUMBLE_FRAMES-th frame pulse, counted from FALL entry. Mirrors return to the reset values (0/1) on entry to IDLE.
- Not defined: left_mirror_out is constantly 0 and right_mirror_out is constantly 1. No tumble counter is built.

## Test plan
- Reset, then trigger with origin (100,200), then 8 frame pulses → positions stay left (100,200), right (108,200). Frame 9 → vy=1, y=201, left_x=99, right_x=109. Frame 10 → y=203.
- Origin (100,600), run to landing → vy saturates at 12. y is clamped to 708. done_out is high exactly one cycle. active_out falls the next cycle.
- Origin x=2, DRIFT=1 → left_x reaches 0 and stays 0. Origin x=1270 → right_x saturates at 1272.
- Trigger and new_frame same cycle in IDLE → HOLD still needs 8 further pulses. Re-trigger during FALL → ignored; positions continue unchanged.
- Deassert rst_n_in mid-FALL, between clock edges → outputs return to reset values asynchronously. No done_out. A fresh trigger then works.
- With HEART_TUMBLE_EN, origin (100,200) → mirrors flip on FALL frames 4, 8, 12. Without it → mirrors stay 0/1 throughout.

Source files
------------

// File: rtl/heart_break_animator_if.sv
// Signal bundle between game logic / pixel pipeline (master) and heart_break_animator (slave).
// trigger_in and new_frame_in are single-cycle strobes with no back-pressure: the animator is always ready and consumes or ignores a strobe in the cycle it is high.
interface heart_break_animator_if;
  logic        trigger_in;
  logic        new_frame_in;
  logic [10:0] origin_x_in;
  logic [9:0]  origin_y_in;
  logic [10:0] left_x_out;
  logic [10:0] right_x_out;
  logic [9:0]  left_y_out;
  logic [9:0]  right_y_out;
  logic        left_mirror_out;
  logic        right_mirror_out;
  logic        active_out;
  logic        done_out;
  logic [1:0]  state_dbg;

  modport master (
    output trigger_in, new_frame_in, origin_x_in, origin_y_in,
    input  left_x_out, right_x_out, left_y_out, right_y_out,
    input  left_mirror_out, right_mirror_out, active_out, done_out, state_dbg
  );

  modport slave (
    input  trigger_in, new_frame_in, origin_x_in, origin_y_in,
    output left_x_out, right_x_out, left_y_out, right_y_out,
    output left_mirror_out, right_mirror_out, active_out, done_out, state_dbg
  );
endinterface

// File: rtl/heart_break_animator.sv
// Broken-heart animation: hold the cracked halves, then drop them under gravity while they drift apart.
// Optional macro HEART_TUMBLE_EN: mirror outputs toggle every TUMBLE_FRAMES fall frames.
module heart_break_animator #(
  parameter int HOLD_FRAMES   = 8,
  parameter int GRAVITY       = 1,
  parameter int VMAX          = 12,
  parameter int DRIFT         = 1,
  parameter int FLOOR_Y       = 720,
  parameter int SCREEN_W      = 1280,
  parameter int SPRITE_W      = 8,
`ifdef HEART_TUMBLE_EN
  parameter int SPRITE_H      = 12,
  parameter int TUMBLE_FRAMES = 4
`else
  parameter int SPRITE_H      = 12
`endif
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  heart_break_animator_if.slave anim
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FALL = 2'd2, DONE = 2'd3} state_t;

  localparam int CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_FRAMES - 1);
  localparam logic [10:0]   LAND_Y     = 11'(FLOOR_Y - SPRITE_H);
  localparam logic [10:0]   RIGHT_MAX  = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0]   SPRITE_W_V = 11'(SPRITE_W);
  localparam logic [10:0]   DRIFT_V    = 11'(DRIFT);
  localparam logic [4:0]    VMAX_V     = 5'(VMAX);
  localparam logic [4:0]    GRAV_V     = 5'(GRAVITY);

  state_t          state;
  logic [CW-1:0]   hold_cnt;
  logic [10:0]     left_x, right_x;
  logic [9:0]      y;
  logic [3:0]      vy;
  logic            active, done;

  logic [4:0]      vy_sum, vy_next;
  logic [10:0]     y_next, left_next, right_next;
  logic [11:0]     right_sum;
  logic            lands;

  // Next-frame kinematics; y_next is one bit wider so a near-floor origin cannot wrap.
  always_comb begin
    vy_sum     = {1'b0, vy} + GRAV_V;
    vy_next    = (vy_sum > VMAX_V) ? VMAX_V : vy_sum;
    y_next     = {1'b0, y} + {6'd0, vy_next};
    lands      = (y_next >= LAND_Y);
    left_next  = (left_x < DRIFT_V) ? 11'd0 : (left_x - DRIFT_V);
    right_sum  = {1'b0, right_x} + {1'b0, DRIFT_V};
    right_next = (right_sum > {1'b0, RIGHT_MAX}) ? RIGHT_MAX : right_sum[10:0];
  end

`ifdef HEART_TUMBLE_EN
  localparam int TW = (TUMBLE_FRAMES > 1) ? $clog2(TUMBLE_FRAMES) : 1;
  localparam logic [TW-1:0] TUMBLE_LAST = TW'(TUMBLE_FRAMES - 1);
  logic [TW-1:0] tumble_cnt;
  logic          left_mirror, right_mirror;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      hold_cnt <= '0;
      left_x   <= '0;
      right_x  <= '0;
      y        <= '0;
      vy       <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
`ifdef HEART_TUMBLE_EN
      tumble_cnt   <= '0;
      left_mirror  <= 1'b0;
      right_mirror <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (anim.trigger_in) begin
            left_x   <= anim.origin_x_in;
            right_x  <= anim.origin_x_in + SPRITE_W_V;
            y        <= anim.origin_y_in;
            vy       <= '0;
            hold_cnt <= '0;
            active   <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (anim.new_frame_in) begin
            if (hold_cnt == HOLD_LAST) begin
              state <= FALL;
`ifdef HEART_TUMBLE_EN
              tumble_cnt <= '0;
`endif
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        FALL: begin
          if (anim.new_frame_in) begin
            vy      <= vy_next[3:0];
            left_x  <= left_next;
            right_x <= right_next;
            if (lands) begin
              y     <= LAND_Y[9:0];
              done  <= 1'b1;
              state <= DONE;
            end else begin
              y <= y_next[9:0];
            end
`ifdef HEART_TUMBLE_EN
            if (tumble_cnt == TUMBLE_LAST) begin
              tumble_cnt   <= '0;
              left_mirror  <= ~left_mirror;
              right_mirror <= ~right_mirror;
            end else begin
              tumble_cnt <= tumble_cnt + 1'b1;
            end
`endif
          end
        end
        DONE: begin
          active <= 1'b0;
          state  <= IDLE;
`ifdef HEART_TUMBLE_EN
          left_mirror  <= 1'b0;
          right_mirror <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign anim.left_x_out  = left_x;
  assign anim.right_x_out = right_x;
  assign anim.left_y_out  = y;
  assign anim.right_y_out = y;
  assign anim.active_out  = active;
  assign anim.done_out    = done;
  assign anim.state_dbg   = state;
`ifdef HEART_TUMBLE_EN
  assign anim.left_mirror_out  = left_mirror;
  assign anim.right_mirror_out = right_mirror;
`else
  assign anim.left_mirror_out  = 1'b0;
  assign anim.right_mirror_out = 1'b1;
`endif

endmodule

// File: tb/tb_heart_break_animator.sv
// Self-checking bench for heart_break_animator: cycle-level reference model feeding an expected queue.
module tb_heart_break_animator;
  localparam int W = 46;
  localparam logic [W-1:0] RESET_SNAP = {1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 11'd0, 10'd0, 10'd0};

  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  heart_break_animator_if anim();

  heart_break_animator dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .anim     (anim)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // reference model state: 0 idle, 1 hold, 2 fall, 3 done
  int m_state, m_cnt, m_vy, m_lx, m_rx, m_y, m_tcnt;
  int m_act, m_done, m_lm, m_rm;
  int ox, oy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_vy = 0; m_lx = 0; m_rx = 0; m_y = 0; m_tcnt = 0;
    m_act = 0; m_done = 0; m_lm = 0; m_rm = 1;
  endfunction

  function automatic void model_step(input logic trig, input logic nf);
    int ny;
    m_done = 0;
    case (m_state)
      0: if (trig) begin
        m_lx = ox; m_rx = (ox + 8) % 2048; m_y = oy; m_vy = 0; m_cnt = 0;
        m_act = 1; m_state = 1;
      end
      1: if (nf) begin
        m_cnt++;
        if (m_cnt == 8) begin m_state = 2; m_tcnt = 0; end
      end
      2: if (nf) begin
        m_vy = (m_vy + 1 > 12) ? 12 : m_vy + 1;
        ny = m_y + m_vy;
        m_lx = (m_lx >= 1) ? m_lx - 1 : 0;
        m_rx = (m_rx + 1 > 1272) ? 1272 : m_rx + 1;
`ifdef HEART_TUMBLE_EN
        m_tcnt++;
        if (m_tcnt == 4) begin m_tcnt = 0; m_lm = 1 - m_lm; m_rm = 1 - m_rm; end
`endif
        if (ny >= 708) begin m_y = 708; m_done = 1; m_state = 3; end
        else m_y = ny;
      end
      default: begin
        m_act = 0; m_state = 0; m_lm = 0; m_rm = 1;
      end
    endcase
  endfunction

  function automatic logic [W-1:0] model_snap();
    return {1'(m_act), 1'(m_done), 1'(m_lm), 1'(m_rm), 11'(m_lx), 11'(m_rx), 10'(m_y), 10'(m_y)};
  endfunction

  function automatic logic [W-1:0] dut_snap();
    return {anim.active_out, anim.done_out, anim.left_mirror_out, anim.right_mirror_out,
            anim.left_x_out, anim.right_x_out, anim.left_y_out, anim.right_y_out};
  endfunction

  // Called at posedge+1: drive inputs, advance model, compare after the next edge.
  task automatic step(input logic trig, input logic nf, input string tag);
    anim.trigger_in   = trig;
    anim.new_frame_in = nf;
    model_step(trig, nf);
    exp_q.push_back(model_snap());
    @(posedge clk_in); #1;
    anim.trigger_in   = 1'b0;
    anim.new_frame_in = 1'b0;
    check(tag, {18'd0, dut_snap()}, {18'd0, exp_q.pop_front()});
  endtask

  task automatic frames(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, tag);
      step(1'b0, 1'b0, tag);
    end
  endtask

  task automatic start(input int x, input int y, input string tag);
    ox = x; oy = y;
    anim.origin_x_in = 11'(x);
    anim.origin_y_in = 10'(y);
    step(1'b1, 1'b0, tag);
  endtask

  task automatic run_to_land(input string tag);
    bit landed = 0;
    for (int i = 0; i < 300 && !landed; i++) begin
      step(1'b0, 1'b1, tag);
      if (m_state == 3) begin
        landed = 1;
        check({tag, "_done"}, 64'(anim.done_out), 64'd1);
        check({tag, "_y"}, 64'(anim.left_y_out), 64'd708);
        check({tag, "_act"}, 64'(anim.active_out), 64'd1);
        step(1'b0, 1'b1, {tag, "_after"});
        check({tag, "_done_low"}, 64'(anim.done_out), 64'd0);
        check({tag, "_act_low"}, 64'(anim.active_out), 64'd0);
      end
    end
    if (!landed) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    rst_n_in = 1'b0;
    anim.trigger_in = 1'b0; anim.new_frame_in = 1'b0;
    anim.origin_x_in = '0; anim.origin_y_in = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("reset", {18'd0, dut_snap()}, {18'd0, RESET_SNAP});
    rst_n_in = 1'b1;
    step(1'b0, 1'b1, "idle_frame");

    // basic hold and first fall frames
    start(100, 200, "t1_trig");
    check("t1_trig_lx", 64'(anim.left_x_out), 64'd100);
    check("t1_trig_rx", 64'(anim.right_x_out), 64'd108);
    frames(8, "t1_hold");
    check("t1_hold_y", 64'(anim.left_y_out), 64'd200);
    check("t1_hold_lx", 64'(anim.left_x_out), 64'd100);
    frames(1, "t1_f9");
    check("t1_f9_y", 64'(anim.left_y_out), 64'd201);
    check("t1_f9_lx", 64'(anim.left_x_out), 64'd99);
    check("t1_f9_rx", 64'(anim.right_x_out), 64'd109);
    frames(1, "t1_f10");
    check("t1_f10_y", 64'(anim.right_y_out), 64'd203);
    frames(1, "t1_f11");
    check("t1_f3_mirror", 64'({anim.left_mirror_out, anim.right_mirror_out}), 64'b01);
    frames(1, "t1_f12");
`ifdef HEART_TUMBLE_EN
    check("t1_f4_mirror", 64'({anim.left_mirror_out, anim.right_mirror_out}), 64'b10);
`else
    check("t1_f4_mirror", 64'({anim.left_mirror_out, anim.right_mirror_out}), 64'b01);
`endif
    anim.origin_x_in = 11'd500; anim.origin_y_in = 10'd500;
    step(1'b1, 1'b0, "t1_retrig");
    check("t1_retrig_y", 64'(anim.left_y_out), 64'd210);
    step(1'b1, 1'b1, "t1_retrig_nf");
    frames(7, "t1_fall");
`ifdef HEART_TUMBLE_EN
    check("t1_f12_mirror", 64'({anim.left_mirror_out, anim.right_mirror_out}), 64'b10);
`else
    check("t1_f12_mirror", 64'({anim.left_mirror_out, anim.right_mirror_out}), 64'b01);
`endif
    run_to_land("t1_land");

    // terminal velocity: 600 +1..+12, then +12 per frame
    start(100, 600, "t2_trig");
    frames(8, "t2_hold");
    frames(14, "t2_fall");
    check("t2_vmax_y", 64'(anim.left_y_out), 64'd702);
    run_to_land("t2_land");

    // horizontal saturation
    start(2, 100, "t3_trig");
    frames(10, "t3_fall");
    check("t3_lx_zero", 64'(anim.left_x_out), 64'd0);
    frames(3, "t3_fall2");
    check("t3_lx_stay", 64'(anim.left_x_out), 64'd0);
    run_to_land("t3_land");
    start(1270, 100, "t4_trig");
    check("t4_rx_hold", 64'(anim.right_x_out), 64'd1278);
    frames(9, "t4_fall");
    check("t4_rx_sat", 64'(anim.right_x_out), 64'd1272);
    frames(2, "t4_fall2");
    check("t4_rx_stay", 64'(anim.right_x_out), 64'd1272);
    run_to_land("t4_land");

    // trigger and frame in the same cycle: that frame does not count
    ox = 300; oy = 300;
    anim.origin_x_in = 11'd300; anim.origin_y_in = 10'd300;
    step(1'b1, 1'b1, "t5_trig_nf");
    frames(8, "t5_hold");
    check("t5_hold_y", 64'(anim.left_y_out), 64'd300);
    frames(1, "t5_f9");
    check("t5_f9_y", 64'(anim.left_y_out), 64'd301);

    // asynchronous reset mid-fall
    frames(3, "t6_fall");
    #2 rst_n_in = 1'b0;
    #1;
    check("t6_async_rst", {18'd0, dut_snap()}, {18'd0, RESET_SNAP});
    model_reset();
    @(posedge clk_in); #1;
    check("t6_rst_no_done", 64'(anim.done_out), 64'd0);
    rst_n_in = 1'b1;
    frames(2, "t6_idle");
    start(40, 50, "t6_retrig");
    frames(9, "t6_fall");
    check("t6_fall_y", 64'(anim.left_y_out), 64'd51);

    // interrupt and origin already below floor line
    start(50, 900, "t7_trig");
    frames(8, "t7_hold");
    run_to_land("t7_land");
    frames(2, "t7_idle");

    if (exp_q.size() != 0) check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
